// File: rtl/dma_defs.sv
// Shared encodings and defaults for the DMA burst engine and its FIFO.
package dma_defs;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } dma_state_e;

    localparam logic DirToMem   = 1'b0;
    localparam logic DirFromMem = 1'b1;

    localparam int unsigned DefaultFifoDepth = 8;
    localparam int unsigned DefaultAddrW     = 18;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO with a flow-through head: o_dout is the oldest word whenever !o_empty.
module dma_fifo
    import dma_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
    parameter int unsigned DATA_W     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_W-1:0]           i_din,
    output logic [DATA_W-1:0]           o_dout,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PtrW + 1)'(FIFO_DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PtrW + 1)'(1);
                2'b01:   r_count <= r_count - (PtrW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/dma_burst_engine.sv
// Device-side DMA master: buffers device words in a FIFO and moves them to/from RAM
// one word per granted bus cycle, re-requesting the bus as often as the arbiter demands.
module dma_burst_engine
    import dma_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
    parameter int unsigned ADDR_W     = DefaultAddrW
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [15:0]       i_word_count,
    output logic              o_busy,
    output logic              o_done,
    input  logic [15:0]       i_dev_wdata,
    input  logic              i_dev_wvalid,
    output logic              o_dev_wready,
    output logic [15:0]       o_dev_rdata,
    output logic              o_dev_rvalid,
    input  logic              i_dev_rready,
    output logic              o_dma_req,
    input  logic              i_dma_ack,
    output logic [ADDR_W-1:0] o_dma_addr,
    output logic [15:0]       o_dma_data_in,
    input  logic [15:0]       i_dma_data_out,
    output logic              o_dma_rd,
    output logic              o_dma_wr
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e        r_state;
    dma_state_e        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_remaining;
    logic [15:0]       r_total;
    logic [15:0]       r_pushed;
    logic              r_dir;
    logic              r_inflight;

    logic              w_launch;
    logic              w_req;
    logic              w_xfer;
    logic              w_room;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic [15:0]       w_fifo_din;
    logic [15:0]       w_fifo_dout;
    logic              w_full;
    logic              w_empty;
    logic [CntW-1:0]   w_count;
    logic              w_unused_addr_lsb;

    assign w_unused_addr_lsb = i_base_addr[0];

    assign w_launch = i_start && (r_state == StIdle);

    // A pending read capture already owns one FIFO slot.
    assign w_room = r_inflight ? (w_count < CntW'(FIFO_DEPTH - 1)) : !w_full;

    always_comb begin
        w_req = 1'b0;
        if ((r_state == StRun) && (r_remaining != 16'd0)) begin
            w_req = (r_dir == DirToMem) ? !w_empty : w_room;
        end
    end

    assign w_xfer = w_req && i_dma_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (i_word_count == 16'd0) ? StFlush : StRun;
                end
            end
            StRun: begin
                if (w_xfer && (r_remaining == 16'd1)) begin
                    w_state_next = StFlush;
                end
            end
            StFlush: begin
                if (!r_inflight) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy        = (r_state != StIdle);
        o_done        = (r_state == StFlush) && !r_inflight;
        o_dma_req     = w_req;
        o_dma_wr      = w_xfer && (r_dir == DirToMem);
        o_dma_rd      = w_xfer && (r_dir == DirFromMem);
        o_dma_addr    = w_xfer ? r_addr : '0;
        o_dma_data_in = o_dma_wr ? w_fifo_dout : 16'd0;
        o_dev_wready  = (r_state == StRun) && (r_dir == DirToMem) && !w_full &&
                        (r_pushed != r_total);
        // Read data stays visible after completion until the next start clears it.
        o_dev_rvalid  = (r_dir == DirFromMem) && !w_empty;
        o_dev_rdata   = o_dev_rvalid ? w_fifo_dout : 16'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_total     <= '0;
            r_pushed    <= '0;
            r_dir       <= DirToMem;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= o_dma_rd;
            if (w_launch) begin
                r_addr      <= {i_base_addr[ADDR_W-1:1], 1'b0};
                r_remaining <= i_word_count;
                r_total     <= i_word_count;
                r_pushed    <= '0;
                r_dir       <= i_dir;
            end else begin
                if (w_xfer) begin
                    r_addr      <= r_addr + ADDR_W'(2);
                    r_remaining <= r_remaining - 16'd1;
                end
                if (i_dev_wvalid && o_dev_wready) begin
                    r_pushed <= r_pushed + 16'd1;
                end
            end
        end
    end

    assign w_fifo_push = (r_dir == DirToMem) ? (i_dev_wvalid && o_dev_wready) : r_inflight;
    assign w_fifo_pop  = (r_dir == DirToMem) ? o_dma_wr : (o_dev_rvalid && i_dev_rready);
    assign w_fifo_din  = (r_dir == DirToMem) ? i_dev_wdata : i_dma_data_out;

    dma_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (16)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_launch),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_din   (w_fifo_din),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: device, arbiter and RAM are modelled inline.
module tb_dma_burst_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        dir;
    logic [17:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [15:0] dev_wdata;
    logic        dev_wvalid;
    logic        dev_wready;
    logic [15:0] dev_rdata;
    logic        dev_rvalid;
    logic        dev_rready;
    logic        dma_req;
    logic        dma_ack;
    logic [17:0] dma_addr;
    logic [15:0] dma_data_in;
    logic [15:0] dma_data_out;
    logic        dma_rd;
    logic        dma_wr;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    dma_burst_engine #(
        .FIFO_DEPTH (8),
        .ADDR_W     (18)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_dir          (dir),
        .i_base_addr    (base_addr),
        .i_word_count   (word_count),
        .o_busy         (busy),
        .o_done         (done),
        .i_dev_wdata    (dev_wdata),
        .i_dev_wvalid   (dev_wvalid),
        .o_dev_wready   (dev_wready),
        .o_dev_rdata    (dev_rdata),
        .o_dev_rvalid   (dev_rvalid),
        .i_dev_rready   (dev_rready),
        .o_dma_req      (dma_req),
        .i_dma_ack      (dma_ack),
        .o_dma_addr     (dma_addr),
        .o_dma_data_in  (dma_data_in),
        .i_dma_data_out (dma_data_out),
        .o_dma_rd       (dma_rd),
        .o_dma_wr       (dma_wr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input int i);
        return 16'(16'o1111 * (i + 1));
    endfunction

    function automatic logic [17:0] addr_of(input logic [17:0] b, input int i);
        logic [17:0] a;
        a = b + 18'(2 * i);
        return a;
    endfunction

    function automatic logic [15:0] ram_of(input logic [17:0] a);
        return a[15:0] ^ 16'h5a5a;
    endfunction

    task automatic do_start(input logic d, input logic [17:0] b, input logic [15:0] wc);
        start      = 1'b1;
        dir        = d;
        base_addr  = b;
        word_count = wc;
        step();
        start = 1'b0;
    endtask

    // bursty=1 models an arbiter granting 4 cycles out of every 6.
    task automatic run_write(input logic [17:0] base, input int n, input bit bursty);
        int pushed   = 0;
        int nwr      = 0;
        int last_wr  = -10;
        int bursts   = 0;
        int last_win = -1;
        bit done_seen = 1'b0;
        do_start(1'b0, base, 16'(n));
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            dev_wvalid = (pushed < n);
            dev_wdata  = word_of(pushed);
            dma_ack    = bursty ? ((cyc % 6) < 4) : 1'b1;
            #1;
            if (dev_wvalid && dev_wready) begin
                pushed++;
            end else if (pushed == n) begin
                check("wready_cap", dev_wready, 0);
            end
            if (dma_rd) check("rd_in_write", dma_rd, 0);
            if (dma_wr) begin
                check("wr_ack", dma_ack, 1);
                check("wr_addr", dma_addr, addr_of(base, nwr));
                check("wr_data", dma_data_in, word_of(nwr));
                if ((cyc / 6) != last_win) begin
                    bursts++;
                    last_win = cyc / 6;
                end
                nwr++;
                last_wr = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                check("wr_done_lat", cyc - last_wr, 1);
                check("wr_count", nwr, n);
                check("busy_at_done", busy, 1);
            end
            step();
        end
        check("wr_done_seen", done_seen, 1);
        check("wr_busy_after", busy, 0);
        check("wr_done_pulse", done, 0);
        if (bursty) check("wr_bursts_ge3", bursts >= 3, 1);
    endtask

    // Device holds off for 30 cycles so the FIFO-depth cap on outstanding reads is visible.
    task automatic run_read(input logic [17:0] base, input int n);
        int nrd     = 0;
        int npop    = 0;
        int last_rd = -10;
        int rd_by30 = 0;
        bit pend    = 1'b0;
        bit done_seen = 1'b0;
        logic [17:0] pend_addr = '0;
        dma_ack = 1'b1;
        do_start(1'b1, base, 16'(n));
        for (int cyc = 0; cyc < 300 && !(done_seen && npop == n); cyc++) begin
            dma_data_out = pend ? ram_of(pend_addr) : 16'hdead;
            dev_rready   = (cyc >= 30);
            #1;
            pend = 1'b0;
            if (cyc == 30) rd_by30 = nrd;
            if (dma_wr) check("wr_in_read", dma_wr, 0);
            if (dma_rd) begin
                check("rd_addr", dma_addr, addr_of(base, nrd));
                pend      = 1'b1;
                pend_addr = dma_addr;
                nrd++;
                last_rd = cyc;
            end
            if (dev_rvalid && dev_rready) begin
                check("rd_data", dev_rdata, ram_of(addr_of(base, npop)));
                npop++;
            end
            if (done) begin
                done_seen = 1'b1;
                check("rd_done_lat", cyc - last_rd, 2);
                check("rd_count", nrd, n);
            end
            step();
        end
        check("rd_done_seen", done_seen, 1);
        check("rd_cap", rd_by30, (n < 8) ? n : 8);
        check("rd_popped", npop, n);
        check("rd_drained", dev_rvalid, 0);
        check("rd_busy_after", busy, 0);
    endtask

    initial begin
        int nwr;
        reset        = 1'b1;
        start        = 1'b0;
        dir          = 1'b0;
        base_addr    = '0;
        word_count   = '0;
        dev_wdata    = '0;
        dev_wvalid   = 1'b0;
        dev_rready   = 1'b0;
        dma_ack      = 1'b0;
        dma_data_out = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", dma_req, 0);
        check("rst_rd", dma_rd, 0);
        check("rst_wr", dma_wr, 0);
        check("rst_addr", dma_addr, 0);
        check("rst_data_in", dma_data_in, 0);
        check("rst_rvalid", dev_rvalid, 0);
        check("rst_wready", dev_wready, 0);
        dma_ack = 1'b1;
        #1;
        check("idle_ack_wr", dma_wr, 0);
        check("idle_ack_addr", dma_addr, 0);
        step();

        run_write(18'o1000, 3, 1'b0);
        run_write(18'o10000, 10, 1'b1);
        run_read(18'o2000, 4);
        run_read(18'o20000, 10);
        run_write(18'o777776, 2, 1'b0);

        // Zero-length transfer completes without touching the bus.
        dma_ack = 1'b1;
        do_start(1'b0, 18'o1234, 16'd0);
        check("zero_done", done, 1);
        check("zero_req", dma_req, 0);
        check("zero_wr", dma_wr, 0);
        step();
        check("zero_done_pulse", done, 0);
        check("zero_busy", busy, 0);
        check("zero_req_after", dma_req, 0);

        // Reset lands after the second of six writes.
        nwr = 0;
        dma_ack = 1'b1;
        do_start(1'b0, 18'o3000, 16'd6);
        for (int cyc = 0; cyc < 50 && nwr < 2; cyc++) begin
            dev_wvalid = 1'b1;
            dev_wdata  = word_of(cyc);
            #1;
            if (dma_wr) nwr++;
            if (nwr < 2) step();
        end
        check("mid_two_writes", nwr, 2);
        reset = 1'b1;
        step();
        check("mid_req", dma_req, 0);
        check("mid_wr", dma_wr, 0);
        check("mid_busy", busy, 0);
        check("mid_wready", dev_wready, 0);
        check("mid_rvalid", dev_rvalid, 0);
        reset      = 1'b0;
        dev_wvalid = 1'b0;
        step();
        check("mid_busy_post", busy, 0);
        check("mid_req_post", dma_req, 0);
        run_write(18'o4000, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
